// File: rtl/exe_pipeline_ctrl.sv
// Execute-stage pipeline controller: RAW hazard stall, branch flush, memory-wait freeze, NZCV register.
// Optional operand forwarding is enabled with `define FORWARDING_EN.
module exe_pipeline_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_src1_used,
  input  logic       id_src2_used,
  input  logic       exe_valid,
  input  logic       exe_wb_en,
  input  logic [3:0] exe_dest,
  input  logic       exe_mem_r_en,
  input  logic       exe_s,
  input  logic       exe_branch_taken,
  input  logic [3:0] alu_nzcv,
  input  logic       mem_wb_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       freeze,
  output logic       stall_front,
  output logic       bubble_id_exe,
  output logic       flush_if_id,
  output logic [3:0] status_nzcv,
  output logic       wait_timeout,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt, cnt_inc;
  logic             mem_stall, branch, hazard;
  logic             exe_m1, exe_m2, mem_m1, mem_m2;

  assign mem_stall = mem_req && !mem_ready;
  assign branch    = exe_valid && exe_branch_taken;
  assign exe_m1    = id_src1_used && exe_wb_en && (id_src1 == exe_dest);
  assign exe_m2    = id_src2_used && exe_wb_en && (id_src2 == exe_dest);
  assign mem_m1    = id_src1_used && mem_wb_en && (id_src1 == mem_dest);
  assign mem_m2    = id_src2_used && mem_wb_en && (id_src2 == mem_dest);

`ifdef FORWARDING_EN
  assign hazard   = exe_mem_r_en && (exe_m1 || exe_m2);
  assign fwd_sel1 = rst ? 2'd0 : (exe_m1 && !exe_mem_r_en) ? 2'd1 : mem_m1 ? 2'd2 : 2'd0;
  assign fwd_sel2 = rst ? 2'd0 : (exe_m2 && !exe_mem_r_en) ? 2'd1 : mem_m2 ? 2'd2 : 2'd0;
`else
  assign hazard   = exe_m1 || exe_m2 || mem_m1 || mem_m2;
  assign fwd_sel1 = 2'd0;
  assign fwd_sel2 = 2'd0;
`endif

  // Hazard stalls apply on any cycle where the pipeline advances without a new flush,
  // including the FLUSH cycle and the cycle memory completes.
  always_comb begin
    freeze        = 1'b0;
    stall_front   = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    next_state    = state;
    if (!rst) begin
      case (state)
        RUN, FLUSH: begin
          if (mem_stall) begin
            freeze     = 1'b1;
            next_state = MEM_WAIT;
          end else if (state == RUN && branch) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
            next_state    = FLUSH;
          end else begin
            stall_front   = hazard;
            bubble_id_exe = hazard;
            next_state    = RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            freeze = 1'b1;
          end else if (branch) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
            next_state    = FLUSH;
          end else begin
            stall_front   = hazard;
            bubble_id_exe = hazard;
            next_state    = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign cnt_inc = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
      status_nzcv  <= '0;
    end else begin
      state <= next_state;
      if (state == MEM_WAIT && !mem_ready) begin
        wait_cnt <= cnt_inc;
        if (cnt_inc == MAX_CNT)
          wait_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (exe_valid && exe_s && !freeze)
        status_nzcv <= alu_nzcv;
    end
  end

endmodule

// File: tb/tb_exe_pipeline_ctrl.sv
// Directed self-checking bench for exe_pipeline_ctrl: vector table plus multi-cycle sequences.
module tb_exe_pipeline_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2;
  logic       id_src1_used, id_src2_used;
  logic       exe_valid, exe_wb_en, exe_mem_r_en, exe_s, exe_branch_taken;
  logic [3:0] exe_dest, alu_nzcv, mem_dest;
  logic       mem_wb_en, mem_req, mem_ready;
  logic       freeze, stall_front, bubble_id_exe, flush_if_id, wait_timeout;
  logic [3:0] status_nzcv;
  logic [1:0] fwd_sel1, fwd_sel2;

  int checks = 0;
  int errors = 0;

  exe_pipeline_ctrl #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s), .exe_branch_taken(exe_branch_taken),
    .alu_nzcv(alu_nzcv), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze(freeze), .stall_front(stall_front), .bubble_id_exe(bubble_id_exe),
    .flush_if_id(flush_if_id), .status_nzcv(status_nzcv), .wait_timeout(wait_timeout),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src1, src2;
    logic       u1, u2, ev, ewb;
    logic [3:0] edst;
    logic       eld, es, ebr;
    logic [3:0] nzcv;
    logic       mwb;
    logic [3:0] mdst;
    logic       mreq, mrdy;
    logic       x_frz, x_stl_nf, x_stl_f, x_fl;
    logic [1:0] x_f1, x_f2;
    logic [3:0] x_st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_src1_used = 0; id_src2_used = 0;
    exe_valid = 0; exe_wb_en = 0; exe_dest = '0; exe_mem_r_en = 0; exe_s = 0;
    exe_branch_taken = 0; alu_nzcv = '0; mem_wb_en = 0; mem_dest = '0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Leaves the DUT in RUN, idle, at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drive(input vec_t v);
    id_src1 = v.src1; id_src2 = v.src2; id_src1_used = v.u1; id_src2_used = v.u2;
    exe_valid = v.ev; exe_wb_en = v.ewb; exe_dest = v.edst; exe_mem_r_en = v.eld;
    exe_s = v.es; exe_branch_taken = v.ebr; alu_nzcv = v.nzcv;
    mem_wb_en = v.mwb; mem_dest = v.mdst; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  initial begin
    vec_t v;
    logic x_stall;

    // Table: each vector applied from a fresh RUN state.
    v = '{default:'0}; tbl.push_back(v);
    v = '{default:'0}; v.ev = 1; v.es = 1; v.nzcv = 4'b0110; v.x_st = 4'b0110; tbl.push_back(v);
    v = '{default:'0}; v.ev = 1; v.es = 1; v.nzcv = 4'b0110; v.mreq = 1; v.x_frz = 1; tbl.push_back(v);
    v = '{default:'0}; v.ev = 1; v.ebr = 1; v.x_fl = 1; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.u1 = 1; v.ewb = 1; v.edst = 3; v.x_stl_nf = 1; v.x_f1 = 1; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.u1 = 1; v.ewb = 1; v.edst = 3; v.eld = 1; v.x_stl_nf = 1; v.x_stl_f = 1; tbl.push_back(v);
    v = '{default:'0}; v.src2 = 5; v.u2 = 1; v.mwb = 1; v.mdst = 5; v.x_stl_nf = 1; v.x_f2 = 2; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.ewb = 1; v.edst = 3; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.u1 = 1; v.edst = 3; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 4; v.u1 = 1; v.ewb = 1; v.edst = 4; v.mwb = 1; v.mdst = 4; v.x_stl_nf = 1; v.x_f1 = 1; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.u1 = 1; v.ewb = 1; v.edst = 3; v.mreq = 1; v.x_frz = 1; v.x_f1 = 1; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 3; v.u1 = 1; v.ewb = 1; v.edst = 3; v.ev = 1; v.ebr = 1; v.x_fl = 1; v.x_f1 = 1; tbl.push_back(v);
    v = '{default:'0}; v.mreq = 1; v.mrdy = 1; v.ev = 1; v.es = 1; v.nzcv = 4'b1111; v.x_st = 4'b1111; tbl.push_back(v);
    v = '{default:'0}; v.ebr = 1; tbl.push_back(v);
    v = '{default:'0}; v.src1 = 2; v.u1 = 1; v.src2 = 2; v.u2 = 1; v.mwb = 1; v.mdst = 2; v.ewb = 1; v.edst = 7;
    v.x_stl_nf = 1; v.x_f1 = 2; v.x_f2 = 2; tbl.push_back(v);

    rst = 1;
    clear_inputs();

    // Controls are masked while rst is high, even with freeze/flush/hazard stimulus.
    @(negedge clk);
    mem_req = 1; exe_valid = 1; exe_branch_taken = 1;
    id_src1 = 3; id_src1_used = 1; exe_wb_en = 1; exe_dest = 3;
    #1;
    chk("rst_freeze", freeze, 0);
    chk("rst_flush", flush_if_id, 0);
    chk("rst_bubble", bubble_id_exe, 0);
    chk("rst_stall", stall_front, 0);
    chk("rst_fwd1", fwd_sel1, 0);
    @(posedge clk); #1;
    chk("rst_status", status_nzcv, 0);
    chk("rst_timeout", wait_timeout, 0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    #1;
    chk("idle_freeze", freeze, 0);
    chk("idle_flush", flush_if_id, 0);
    chk("idle_stall", stall_front, 0);
    chk("idle_status", status_nzcv, 0);

    foreach (tbl[i]) begin
      do_reset();
      drive(tbl[i]);
      x_stall = FWD ? tbl[i].x_stl_f : tbl[i].x_stl_nf;
      #1;
      chk($sformatf("v%0d_freeze", i), freeze, tbl[i].x_frz);
      chk($sformatf("v%0d_stall", i), stall_front, x_stall);
      chk($sformatf("v%0d_bubble", i), bubble_id_exe, x_stall | tbl[i].x_fl);
      chk($sformatf("v%0d_flush", i), flush_if_id, tbl[i].x_fl);
      chk($sformatf("v%0d_fwd1", i), fwd_sel1, FWD ? tbl[i].x_f1 : 2'd0);
      chk($sformatf("v%0d_fwd2", i), fwd_sel2, FWD ? tbl[i].x_f2 : 2'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_status", i), status_nzcv, tbl[i].x_st);
    end

    // Branch flush lasts one cycle.
    do_reset();
    exe_valid = 1; exe_branch_taken = 1;
    #1;
    chk("br_flush", flush_if_id, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("br_flush_after", flush_if_id, 0);
    chk("br_bubble_after", bubble_id_exe, 0);

    // Long memory wait: timeout after 16 MEM_WAIT cycles, sticky until rst.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wait%0d_freeze", k), freeze, 1);
      chk($sformatf("wait%0d_timeout", k), wait_timeout, (k >= 17) ? 4'd1 : 4'd0);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("ready_freeze", freeze, 0);
    @(posedge clk); #1;
    chk("ready_timeout_sticky", wait_timeout, 1);
    @(negedge clk);
    mem_req = 0; mem_ready = 0;
    #1;
    chk("post_wait_freeze", freeze, 0);
    chk("post_wait_timeout", wait_timeout, 1);
    mem_req = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("midwait_rst_timeout", wait_timeout, 0);
    @(negedge clk);
    rst = 0; mem_req = 0;
    #1;
    chk("midwait_rst_run", freeze, 0);

    // Taken branch stuck behind a memory wait, with a flag update pending.
    do_reset();
    exe_valid = 1; exe_branch_taken = 1; exe_s = 1; alu_nzcv = 4'b1001;
    mem_req = 1; mem_ready = 0;
    #1;
    chk("bw_freeze", freeze, 1);
    chk("bw_flush", flush_if_id, 0);
    chk("bw_bubble", bubble_id_exe, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bw_wait_freeze", freeze, 1);
      chk("bw_wait_flush", flush_if_id, 0);
      chk("bw_wait_status", status_nzcv, 0);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("bw_ready_freeze", freeze, 0);
    chk("bw_ready_flush", flush_if_id, 1);
    chk("bw_ready_bubble", bubble_id_exe, 1);
    @(posedge clk); #1;
    chk("bw_status", status_nzcv, 4'b1001);
    @(negedge clk);
    clear_inputs();
    id_src1 = 3; id_src1_used = 1; exe_valid = 1; exe_wb_en = 1; exe_dest = 3; exe_mem_r_en = 1;
    #1;
    chk("fl_flush", flush_if_id, 0);
    chk("fl_freeze", freeze, 0);
    chk("fl_stall", stall_front, 1);
    chk("fl_bubble", bubble_id_exe, 1);
    @(negedge clk);
    clear_inputs();
    exe_valid = 1; exe_branch_taken = 1;
    #1;
    chk("back_to_run_flush", flush_if_id, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
